// File: rtl/zeroheti_dbg_rst_ctrl.sv
// zeroheti_dbg_rst_ctrl
// Non-debug-reset (ndmreset) sequencer and per-hart debug-request gate.
// Stretches the debug module's ndmreset request into a minimum-width system
// reset, then releases the system reset followed by each hart's reset in
// ascending index order, StaggerCycles apart. Debug requests only reach harts
// whose reset has been released.
// Optional feature macro: ZEROHETI_DBG_HALTONRESET_EN adds a per-hart
// halt-on-reset pending bit that raises a debug request after release.
module zeroheti_dbg_rst_ctrl #(
    parameter int unsigned NrHarts       = 1,
    parameter int unsigned AssertCycles  = 16,
    parameter int unsigned StaggerCycles = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               testmode_i,
    input  logic               ndmreset_req_i,
    input  logic [NrHarts-1:0] debug_req_i,
    input  logic [NrHarts-1:0] haltonreset_i,
    input  logic [NrHarts-1:0] hart_dbg_mode_i,
    output logic               sys_rst_no,
    output logic [NrHarts-1:0] hart_rst_no,
    output logic [NrHarts-1:0] debug_req_o,
    output logic               busy_o
);

    localparam int unsigned MaxCycles = (AssertCycles > StaggerCycles) ? AssertCycles : StaggerCycles;
    localparam int unsigned CntW      = $clog2(MaxCycles) + 1;
    localparam int unsigned IdxW      = $clog2(NrHarts) + 1;

    localparam logic [CntW-1:0] AssertLast  = CntW'(AssertCycles - 1);
    localparam logic [CntW-1:0] StaggerLast = CntW'(StaggerCycles - 1);
    localparam logic [IdxW-1:0] LastHart    = IdxW'(NrHarts - 1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [IdxW-1:0]    idx_q, idx_d;
    logic               sys_rst_q, sys_rst_d;
    logic [NrHarts-1:0] hart_rst_q, hart_rst_d;
    logic [NrHarts-1:0] dbg_req_q, dbg_req_d;
    logic               busy_q, busy_d;

    // State, counters and registered outputs; power-on lands in RELEASE so
    // deassertion of rst_ni gives a staggered release without an ASSERT phase.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_RELEASE;
            cnt_q      <= '0;
            idx_q      <= '0;
            sys_rst_q  <= 1'b0;
            hart_rst_q <= '0;
            dbg_req_q  <= '0;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            sys_rst_q  <= sys_rst_d;
            hart_rst_q <= hart_rst_d;
            dbg_req_q  <= dbg_req_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state logic: assertion counter saturates, so a held request simply
    // keeps the FSM in ASSERT until it drops.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        unique case (state_q)
            ST_RUN: begin
                if (ndmreset_req_i) begin
                    state_d = ST_ASSERT;
                    cnt_d   = '0;
                end
            end
            ST_ASSERT: begin
                if (cnt_q == AssertLast) begin
                    if (!ndmreset_req_i) begin
                        state_d = ST_RELEASE;
                        cnt_d   = '0;
                        idx_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            ST_RELEASE: begin
                if (ndmreset_req_i) begin
                    state_d = ST_ASSERT;
                    cnt_d   = '0;
                end else if (cnt_q == StaggerLast) begin
                    cnt_d = '0;
                    idx_d = idx_q + IdxW'(1);
                    if (idx_q == LastHart) begin
                        state_d = ST_RUN;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = ST_ASSERT;
                cnt_d   = '0;
            end
        endcase
    end

    // Output logic: computes the next registered reset/busy values so every
    // reset change lands on the same edge as the matching state transition.
    always_comb begin
        sys_rst_d  = sys_rst_q;
        hart_rst_d = hart_rst_q;
        busy_d     = busy_q;
        unique case (state_q)
            ST_RUN: begin
                if (ndmreset_req_i) begin
                    sys_rst_d  = 1'b0;
                    hart_rst_d = '0;
                    busy_d     = 1'b1;
                end else begin
                    sys_rst_d  = 1'b1;
                    hart_rst_d = '1;
                    busy_d     = 1'b0;
                end
            end
            ST_RELEASE: begin
                if (ndmreset_req_i) begin
                    sys_rst_d  = 1'b0;
                    hart_rst_d = '0;
                    busy_d     = 1'b1;
                end else begin
                    sys_rst_d = 1'b1;
                    busy_d    = 1'b1;
                    if (cnt_q == StaggerLast) begin
                        for (int i = 0; i < int'(NrHarts); i++) begin
                            if (idx_q == IdxW'(i)) begin
                                hart_rst_d[i] = 1'b1;
                            end
                        end
                        if (idx_q == LastHart) begin
                            busy_d = 1'b0;
                        end
                    end
                end
            end
            default: begin
                sys_rst_d  = 1'b0;
                hart_rst_d = '0;
                busy_d     = 1'b1;
            end
        endcase
    end

`ifdef ZEROHETI_DBG_HALTONRESET_EN
    logic [NrHarts-1:0] pending_q, pending_d;
    logic [NrHarts-1:0] pending_eff;
    logic [NrHarts-1:0] released_now;
    logic               enter_assert;

    // Halt-on-reset pending bits: set when a hart leaves reset, cleared once
    // the hart reports debug mode or the reset sequence restarts.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // Pending/debug combine; the debug-mode acknowledge masks the request on
    // the edge it is seen so the request drops one edge later.
    always_comb begin
        enter_assert = (state_d == ST_ASSERT) && (state_q != ST_ASSERT);
        released_now = hart_rst_d & ~hart_rst_q;
        pending_eff  = pending_q & ~hart_dbg_mode_i;
        pending_d    = (pending_q | (released_now & haltonreset_i)) & ~hart_dbg_mode_i;
        if (enter_assert) begin
            pending_d = '0;
        end
        dbg_req_d = (debug_req_i | pending_eff) & hart_rst_d;
    end
`else
    logic unused_halt_inputs;
    assign unused_halt_inputs = ^{haltonreset_i, hart_dbg_mode_i};

    // Debug request gate: harts held in reset never see a request.
    always_comb begin
        dbg_req_d = debug_req_i & hart_rst_d;
    end
`endif

    assign sys_rst_no  = testmode_i ? rst_ni : sys_rst_q;
    assign hart_rst_no = testmode_i ? {NrHarts{rst_ni}} : hart_rst_q;
    assign debug_req_o = testmode_i ? '0 : dbg_req_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_zeroheti_dbg_rst_ctrl.sv
// Testbench for zeroheti_dbg_rst_ctrl with NrHarts=3, AssertCycles=4,
// StaggerCycles=2. Expected outputs come from a hand-written vector table.
module tb_zeroheti_dbg_rst_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       testmode;
    logic       ndmreset_req;
    logic [2:0] debug_req;
    logic [2:0] haltonreset;
    logic [2:0] dbg_mode;
    logic       sys_rst_n;
    logic [2:0] hart_rst_n;
    logic [2:0] debug_req_out;
    logic       busy;

    int total = 0;
    int bad   = 0;

`ifdef ZEROHETI_DBG_HALTONRESET_EN
    localparam logic [2:0] HaltDbg = 3'b010;
`else
    localparam logic [2:0] HaltDbg = 3'b000;
`endif

    typedef struct {
        logic       req;
        logic [2:0] dbg;
        logic       sys;
        logic [2:0] hart;
        logic [2:0] dreq;
        logic       busy;
    } vec_t;

    typedef struct {
        logic       sys;
        logic [2:0] hart;
        logic [2:0] dreq;
        logic       busy;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    zeroheti_dbg_rst_ctrl #(
        .NrHarts      (3),
        .AssertCycles (4),
        .StaggerCycles(2)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .testmode_i     (testmode),
        .ndmreset_req_i (ndmreset_req),
        .debug_req_i    (debug_req),
        .haltonreset_i  (haltonreset),
        .hart_dbg_mode_i(dbg_mode),
        .sys_rst_no     (sys_rst_n),
        .hart_rst_no    (hart_rst_n),
        .debug_req_o    (debug_req_out),
        .busy_o         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input exp_t e);
        check({tag, " sys_rst_no"}, {2'b00, sys_rst_n}, {2'b00, e.sys});
        check({tag, " hart_rst_no"}, hart_rst_n, e.hart);
        check({tag, " debug_req_o"}, debug_req_out, e.dreq);
        check({tag, " busy_o"}, {2'b00, busy}, {2'b00, e.busy});
    endtask

    // Drive one cycle of inputs, queue the expectation, compare after the edge.
    task automatic step(input string tag, input logic req, input logic [2:0] dbg,
                        input logic [2:0] halt, input logic [2:0] mode,
                        input logic e_sys, input logic [2:0] e_hart,
                        input logic [2:0] e_dreq, input logic e_busy);
        exp_t e;
        ndmreset_req = req;
        debug_req    = dbg;
        haltonreset  = halt;
        dbg_mode     = mode;
        sb.push_back('{e_sys, e_hart, e_dreq, e_busy});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_all(tag, e);
    endtask

    task automatic add(input logic req, input logic [2:0] dbg, input logic sys,
                       input logic [2:0] hart, input logic [2:0] dreq, input logic bsy);
        tbl.push_back('{req, dbg, sys, hart, dreq, bsy});
    endtask

    task automatic add_held(input int n, input logic req);
        for (int k = 0; k < n; k++) add(req, 3'b000, 1'b0, 3'b000, 3'b000, 1'b1);
    endtask

    task automatic add_release_tail();
        add(1'b0, 3'b000, 1'b1, 3'b000, 3'b000, 1'b1);
        add(1'b0, 3'b000, 1'b1, 3'b001, 3'b000, 1'b1);
        add(1'b0, 3'b000, 1'b1, 3'b001, 3'b000, 1'b1);
        add(1'b0, 3'b000, 1'b1, 3'b011, 3'b000, 1'b1);
        add(1'b0, 3'b000, 1'b1, 3'b011, 3'b000, 1'b1);
        add(1'b0, 3'b000, 1'b1, 3'b111, 3'b000, 1'b0);
    endtask

    initial begin
        exp_t e;
        rst_n        = 1'b0;
        testmode     = 1'b0;
        ndmreset_req = 1'b0;
        debug_req    = 3'b000;
        haltonreset  = 3'b000;
        dbg_mode     = 3'b000;

        // Power-on release with debug gating, then 1-cycle pulse, 10-cycle
        // hold and a re-request right after hart0 is released.
        add(1'b0, 3'b000, 1'b1, 3'b000, 3'b000, 1'b1);
        add(1'b0, 3'b000, 1'b1, 3'b001, 3'b000, 1'b1);
        add(1'b0, 3'b111, 1'b1, 3'b001, 3'b001, 1'b1);
        add(1'b0, 3'b111, 1'b1, 3'b011, 3'b011, 1'b1);
        add(1'b0, 3'b000, 1'b1, 3'b011, 3'b000, 1'b1);
        add(1'b0, 3'b000, 1'b1, 3'b111, 3'b000, 1'b0);
        add(1'b0, 3'b101, 1'b1, 3'b111, 3'b101, 1'b0);
        add(1'b0, 3'b000, 1'b1, 3'b111, 3'b000, 1'b0);
        add_held(1, 1'b1);
        add_held(4, 1'b0);
        add_release_tail();
        add_held(10, 1'b1);
        add_held(1, 1'b0);
        add(1'b0, 3'b000, 1'b1, 3'b000, 3'b000, 1'b1);
        add(1'b0, 3'b000, 1'b1, 3'b001, 3'b000, 1'b1);
        add(1'b1, 3'b111, 1'b0, 3'b000, 3'b000, 1'b1);
        add_held(4, 1'b0);
        add_release_tail();

        repeat (2) @(posedge clk);
        #1;
        e = '{1'b0, 3'b000, 3'b000, 1'b1};
        check_all("reset", e);

        rst_n = 1'b1;
        for (int i = 0; i < tbl.size(); i++) begin
            step($sformatf("vec%0d", i), tbl[i].req, tbl[i].dbg, 3'b000, 3'b000,
                 tbl[i].sys, tbl[i].hart, tbl[i].dreq, tbl[i].busy);
        end

        // Testmode bypass: resets follow rst_ni combinationally, no debug req.
        testmode  = 1'b1;
        debug_req = 3'b111;
        #1;
        e = '{1'b1, 3'b111, 3'b000, 1'b0};
        check_all("tm run", e);
        @(posedge clk);
        #1;
        check_all("tm run edge", e);
        rst_n = 1'b0;
        #1;
        e = '{1'b0, 3'b000, 3'b000, 1'b1};
        check_all("tm rst low", e);
        testmode  = 1'b0;
        debug_req = 3'b000;
        #1;
        check_all("tm off rst low", e);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Second power-on release.
        step("por1", 1'b0, 3'b000, 3'b000, 3'b000, 1'b1, 3'b000, 3'b000, 1'b1);
        step("por2", 1'b0, 3'b000, 3'b000, 3'b000, 1'b1, 3'b001, 3'b000, 1'b1);
        step("por3", 1'b0, 3'b000, 3'b000, 3'b000, 1'b1, 3'b001, 3'b000, 1'b1);
        step("por4", 1'b0, 3'b000, 3'b000, 3'b000, 1'b1, 3'b011, 3'b000, 1'b1);
        step("por5", 1'b0, 3'b000, 3'b000, 3'b000, 1'b1, 3'b011, 3'b000, 1'b1);
        step("por6", 1'b0, 3'b000, 3'b000, 3'b000, 1'b1, 3'b111, 3'b000, 1'b0);

        // Halt-on-reset for hart1.
        step("hor0", 1'b1, 3'b000, 3'b010, 3'b000, 1'b0, 3'b000, 3'b000, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            step($sformatf("hor%0d", k), 1'b0, 3'b000, 3'b010, 3'b000, 1'b0, 3'b000, 3'b000, 1'b1);
        end
        step("hor5",  1'b0, 3'b000, 3'b010, 3'b000, 1'b1, 3'b000, 3'b000, 1'b1);
        step("hor6",  1'b0, 3'b000, 3'b010, 3'b000, 1'b1, 3'b001, 3'b000, 1'b1);
        step("hor7",  1'b0, 3'b000, 3'b010, 3'b000, 1'b1, 3'b001, 3'b000, 1'b1);
        step("hor8",  1'b0, 3'b000, 3'b010, 3'b000, 1'b1, 3'b011, 3'b000, 1'b1);
        step("hor9",  1'b0, 3'b000, 3'b010, 3'b000, 1'b1, 3'b011, HaltDbg, 1'b1);
        step("hor10", 1'b0, 3'b000, 3'b010, 3'b000, 1'b1, 3'b111, HaltDbg, 1'b0);
        step("hor11", 1'b0, 3'b000, 3'b010, 3'b000, 1'b1, 3'b111, HaltDbg, 1'b0);
        step("hor12", 1'b0, 3'b000, 3'b010, 3'b010, 1'b1, 3'b111, 3'b000, 1'b0);
        step("hor13", 1'b0, 3'b000, 3'b010, 3'b000, 1'b1, 3'b111, 3'b000, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/zeroheti_dbg_rst_ctrl.md
Name: zeroheti_dbg_rst_ctrl

Overview:
Parametrised non-debug-reset (ndmreset) and per-hart debug-request controller sitting between the debug module and up to NrHarts cores. It turns the DM's ndmreset request into a minimum-width system reset plus staggered per-hart reset release. It masks debug requests to harts held in reset and, optionally, raises halt-on-reset requests. It supersedes the single-hart scheme in which ndmreset from the DM was left unconnected.

Parameters:
NrHarts, 1, number of hart channels (>=1)
AssertCycles, 16, minimum reset assertion length in clk_i cycles (>=1)
StaggerCycles, 4, cycles between successive hart releases (>=1)

Ports:
clk_i  in  1  system clock
rst_ni  in  1  asynchronous active-low reset
testmode_i  in  1  DFT bypass
ndmreset_req_i  in  1  ndmreset request from DM, level
debug_req_i  in  NrHarts  per-hart debug request from DM
haltonreset_i  in  NrHarts  per-hart halt-on-reset enable (used only with macro)
hart_dbg_mode_i  in  NrHarts  hart is in debug mode (used only with macro)
sys_rst_no  out  1  active-low peripheral/interconnect reset
hart_rst_no  out  NrHarts  active-low per-hart reset
debug_req_o  out  NrHarts  gated debug request to harts
busy_o  out  1  reset sequence in progress

Behaviour:
- Single clock clk_i. rst_ni is asynchronous, active-low.
- Reset values: state=RELEASE, cnt=0, idx=0, sys_rst_no=0, hart_rst_no='0, debug_req_o='0, busy_o=1.
- All outputs are registered, except in testmode.
- FSM states: RUN, ASSERT, RELEASE.
- RUN:
  - sys_rst_no=1, hart_rst_no='1, busy_o=0.
  - ndmreset_req_i=1 sampled -> ASSERT, cnt=0. All resets go low on that same edge.
- ASSERT:
  - All resets low, busy_o=1.
  - cnt increments, saturating at AssertCycles-1.
  - Exit to RELEASE (cnt=0, idx=0) when cnt==AssertCycles-1 and ndmreset_req_i=0.
  - A request held high extends the assertion indefinitely. Minimum width is AssertCycles cycles even for a 1-cycle request pulse.
- RELEASE:
  - sys_rst_no goes to 1 on the first edge in RELEASE.
  - cnt counts 0..StaggerCycles-1. On the edge where cnt==StaggerCycles-1: hart_rst_no[idx]<=1, idx++, cnt=0.
  - Harts release in ascending index order, hart i at edge (i+1)*StaggerCycles after RELEASE entry.
  - After releasing hart NrHarts-1 -> RUN; busy_o falls on the same edge.
- ndmreset_req_i=1 during RELEASE: immediate return to ASSERT with cnt=0. All resets, including already-released harts, are reasserted on the next edge.
- Power-on: reset enters RELEASE directly, so deassertion of rst_ni yields a staggered release without an ASSERT phase.
- debug_req_o[i] <= debug_req_i[i] & hart released. Forced 0 while hart_rst_no[i]=0. One-cycle latency.
- testmode_i=1:
  - sys_rst_no and every hart_rst_no equal rst_ni combinationally; debug_req_o=0.
  - The FSM keeps running but does not drive the outputs.
- idx width is $clog2(NrHarts)+1. cnt width is $clog2(max(AssertCycles,StaggerCycles))+1. No wrap is possible.

Optional Feature:
Macro ZEROHETI_DBG_HALTONRESET_EN.
- Defined:
  - Per-hart pending bit, reset 0.
  - Set on the edge hart i is released if haltonreset_i[i]=1.
  - Cleared when hart_dbg_mode_i[i]=1, or on re-entry to ASSERT (clear wins over set).
  - debug_req_o[i] <= (debug_req_i[i] | pending[i]) & released.
- Not defined: no pending state; haltonreset_i and hart_dbg_mode_i are ignored. The ports remain so top-level wiring is identical.

Test Plan:
All scenarios use NrHarts=3, AssertCycles=4, StaggerCycles=2.
- Power-on: rst_ni rises before edge 0 -> sys_rst_no=1 after edge 1; hart_rst_no 3'b001 @edge2, 3'b011 @edge4, 3'b111 @edge6; busy_o=0 @edge6.
- 1-cycle ndmreset_req_i pulse in RUN -> all resets 0 for exactly 4 cycles, then sys_rst_no=1 next edge, then harts at +2/+4/+6 edges.
- ndmreset_req_i held 10 cycles -> resets stay low for all 10 plus the exit edge; release sequence as above.
- ndmreset_req_i=1 after hart0 released -> hart_rst_no=3'b000, sys_rst_no=0 next edge; full 4-cycle ASSERT repeats.
- debug_req_i=3'b111 during RELEASE with hart_rst_no=3'b001 -> debug_req_o=3'b001; testmode_i=1, rst_ni=0 -> all resets 0 combinationally, debug_req_o=0.
- Macro on, haltonreset_i=3'b010 -> debug_req_o[1] rises the edge after hart1 is released and holds until hart_dbg_mode_i[1]=1, then falls next edge. Macro off: stays 0.
